// File: rtl/lb_conv3x3_engine.sv
// rtl/lb_conv3x3_engine.sv - 3x3 convolution engine fed by a rotating three-row line buffer
module lb_conv3x3_engine #(
    parameter int DW      = 8,
    parameter int IMG_W   = 100,
    parameter int AW      = 7,
    parameter int STRIDE  = 1,
    parameter int ACC_W   = 20,
    parameter int OUT_W   = 16,
    parameter int RELU_EN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              row_sel,
    input  logic [9*DW-1:0]         weights,
    input  logic signed [ACC_W-1:0] bias,
    output logic                    lb_rd_en,
    output logic [AW-1:0]           lb_rd_addr,
    input  logic                    lb_rd_valid,
    input  logic [3*DW-1:0]         lb0_data,
    input  logic [3*DW-1:0]         lb1_data,
    input  logic [3*DW-1:0]         lb2_data,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    idle,
    output logic                    row_done
);

    localparam int N_WIN = (IMG_W - 3) / STRIDE + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'((N_WIN - 1) * STRIDE);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_MAC, S_OUT} state_t;

    state_t                  state;
    logic [1:0]              rot_q;
    logic [9*DW-1:0]         w_q;
    logic signed [ACC_W-1:0] bias_q;
    logic [3*DW-1:0]         top_q, mid_q, bot_q;

    logic [3*DW-1:0]         row_v;
    logic signed [ACC_W-1:0] pe, we, acc, acc_r;
    logic [OUT_W-1:0]        sat_res;

    // Pixels are zero-extended, weights sign-extended, so the product is a plain signed MAC.
    always_comb begin
        row_v = '0;
        pe    = '0;
        we    = '0;
        acc   = bias_q;
        for (int r = 0; r < 3; r++) begin
            row_v = (r == 0) ? top_q : (r == 1) ? mid_q : bot_q;
            for (int p = 0; p < 3; p++) begin
                pe  = $signed({{(ACC_W-DW){1'b0}}, row_v[p*DW +: DW]});
                we  = $signed({{(ACC_W-DW){w_q[(3*r+p)*DW + DW-1]}}, w_q[(3*r+p)*DW +: DW]});
                acc = acc + pe * we;
            end
        end
        acc_r = (RELU_EN != 0 && acc < 0) ? '0 : acc;
        if (acc_r > SAT_MAX)
            sat_res = SAT_MAX[OUT_W-1:0];
        else if (acc_r < SAT_MIN)
            sat_res = SAT_MIN[OUT_W-1:0];
        else
            sat_res = acc_r[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rot_q      <= '0;
            w_q        <= '0;
            bias_q     <= '0;
            top_q      <= '0;
            mid_q      <= '0;
            bot_q      <= '0;
            lb_rd_en   <= 1'b0;
            lb_rd_addr <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            idle       <= 1'b1;
            row_done   <= 1'b0;
        end else begin
            row_done <= 1'b0;
            lb_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The cycle that reports row_done refuses a new row.
                    if (start && !row_done) begin
                        rot_q      <= (row_sel == 2'd3) ? 2'd0 : row_sel;
                        w_q        <= weights;
                        bias_q     <= bias;
                        lb_rd_addr <= '0;
                        idle       <= 1'b0;
                        lb_rd_en   <= 1'b1;
                        state      <= S_READ;
                    end
                end
                S_READ: state <= S_WAIT;
                S_WAIT: begin
                    if (lb_rd_valid) begin
                        case (rot_q)
                            2'd1: begin top_q <= lb1_data; mid_q <= lb2_data; bot_q <= lb0_data; end
                            2'd2: begin top_q <= lb2_data; mid_q <= lb0_data; bot_q <= lb1_data; end
                            default: begin top_q <= lb0_data; mid_q <= lb1_data; bot_q <= lb2_data; end
                        endcase
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    out_data  <= sat_res;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (lb_rd_addr == LAST_ADDR) begin
                            row_done <= 1'b1;
                            idle     <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            lb_rd_addr <= lb_rd_addr + AW'(STRIDE);
                            lb_rd_en   <= 1'b1;
                            state      <= S_READ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
